// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sync_fifo_pkg;

    // Registered status flags, kept together so reset and update stay in one place
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    // Pointer width for a power-of-two depth
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter needs one extra bit so that DEPTH itself is representable
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides which writes are accepted.
module fifo_dp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; pointers and count make stale words unreachable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, programmable almost flags and sticky errors.
// Latency: standard mode 1 cycle rd_en->rd_data; SYNC_FIFO_FWFT_EN shows the head word 1 cycle after its write.
// Backpressure: writes dropped while full (overflow), reads dropped while empty (underflow).
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    fill_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    fifo_status_t      status_q, status_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rd_data;

    fifo_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Accept rules, pointer/count update and next-state flags from the post-update count
    always_comb begin
        wr_acc   = wr_en && !status_q.full;
        rd_acc   = rd_en && !status_q.empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CNT_W'(1);
        end

        status_d.full         = (count_d == CNT_W'(DEPTH));
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= CNT_W'(AF_LEVEL));
        status_d.almost_empty = (count_d <= CNT_W'(AE_LEVEL));
        // Error flags look at the request, not the accept: a rejected attempt is the event
        status_d.overflow     = status_q.overflow  | (wr_en & status_q.full);
        status_d.underflow    = status_q.underflow | (rd_en & status_q.empty);
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= STATUS_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; an empty FIFO drives zero so rd_data is never stale
    assign rd_data  = status_q.empty ? '0 : ram_rd_data;
    assign rd_valid = !status_q.empty;
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read; hold the last word otherwise
    always_comb begin
        rd_data_d  = rd_acc ? ram_rd_data : rd_data_q;
        rd_valid_d = rd_acc;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign fifo_full    = status_q.full;
    assign fifo_empty   = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;
    assign fill_count   = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: exercised through full/empty corner vectors.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] fill_count;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_n;
        bit         we;
        logic [7:0] wd;
        bit         re;
        bit         erv;
        logic [7:0] erd;
        int         cnt;
        logic [5:0] flags;  // {full, empty, almost_full, almost_empty, overflow, underflow}
    } vec_t;

    function automatic vec_t v(input bit r, input bit we, input logic [7:0] wd, input bit re,
                               input bit erv, input logic [7:0] erd, input int cnt,
                               input bit f, input bit e, input bit af, input bit ae,
                               input bit ov, input bit un);
        vec_t t;
        t.rst_n = r;   t.we = we;   t.wd = wd;  t.re = re;
        t.erv   = erv; t.erd = erd; t.cnt = cnt;
        t.flags = {f, e, af, ae, ov, un};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    task automatic drive_edge(input bit r, input bit we, input logic [7:0] wd, input bit re);
        rst_n   = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t t, input int idx);
        drive_edge(t.rst_n, t.we, t.wd, t.re);
        chk($sformatf("v%0d fill_count", idx), 32'(fill_count), 32'(t.cnt));
        chk($sformatf("v%0d flags", idx), 32'(flags_now()), 32'(t.flags));
        chk($sformatf("v%0d rd_valid", idx), 32'(rd_valid), 32'(t.erv));
        if (t.erv || !t.rst_n) begin
            chk($sformatf("v%0d rd_data", idx), 32'(rd_data), 32'(t.erd));
        end
    endtask

`ifndef SYNC_FIFO_FWFT_EN
    logic [7:0] mdl_q[$];

    // Scoreboarded cycle for the streaming test
    task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input string tag);
        bit pop;
        bit push;
        logic [7:0] exp_w;
        pop  = re && (mdl_q.size() > 0);
        push = we && (mdl_q.size() < 8);
        exp_w = 8'h00;
        drive_edge(1'b1, we, wd, re);
        if (pop) exp_w = mdl_q.pop_front();
        if (push) mdl_q.push_back(wd);
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(pop));
        if (pop) chk({tag, " rd_data"}, 32'(rd_data), 32'(exp_w));
        chk({tag, " fill_count"}, 32'(fill_count), 32'(mdl_q.size()));
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        @(negedge clk);

`ifndef SYNC_FIFO_FWFT_EN
        begin
            vec_t tbl[$];
            //              rst we wd     re  rv rd     cnt f  e  af ae ov un
            // reset held two cycles with a write pending, then release
            tbl.push_back(v(0, 1, 8'h55, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            tbl.push_back(v(0, 1, 8'h55, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            tbl.push_back(v(1, 0, 8'h00, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  0, 8'h00, 0,  0, 1, 0, 1, 0, 1));
            tbl.push_back(v(0, 0, 8'h00, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            // fill to full, then one rejected write
            tbl.push_back(v(1, 1, 8'h10, 0,  0, 8'h00, 1,  0, 0, 0, 1, 0, 0));
            tbl.push_back(v(1, 1, 8'h11, 0,  0, 8'h00, 2,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h12, 0,  0, 8'h00, 3,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h13, 0,  0, 8'h00, 4,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h14, 0,  0, 8'h00, 5,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h15, 0,  0, 8'h00, 6,  0, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h16, 0,  0, 8'h00, 7,  0, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'h17, 0,  0, 8'h00, 8,  1, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hFF, 0,  0, 8'h00, 8,  1, 0, 1, 0, 1, 0));
            // drain in order, then one read too many
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h10, 7,  0, 0, 1, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 0,  0, 8'h10, 7,  0, 0, 1, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h11, 6,  0, 0, 1, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h12, 5,  0, 0, 0, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h13, 4,  0, 0, 0, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h14, 3,  0, 0, 0, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h15, 2,  0, 0, 0, 0, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h16, 1,  0, 0, 0, 1, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'h17, 0,  0, 1, 0, 1, 1, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  0, 8'h00, 0,  0, 1, 0, 1, 1, 1));
            tbl.push_back(v(0, 0, 8'h00, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            // simultaneous write+read at count 3 keeps count and order
            tbl.push_back(v(1, 1, 8'hA0, 0,  0, 8'h00, 1,  0, 0, 0, 1, 0, 0));
            tbl.push_back(v(1, 1, 8'hA1, 0,  0, 8'h00, 2,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hA2, 0,  0, 8'h00, 3,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hB0, 1,  1, 8'hA0, 3,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'hA1, 2,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'hA2, 1,  0, 0, 0, 1, 0, 0));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'hB0, 0,  0, 1, 0, 1, 0, 0));
            // simultaneous write+read at full: read wins, write dropped
            tbl.push_back(v(1, 1, 8'hC0, 0,  0, 8'h00, 1,  0, 0, 0, 1, 0, 0));
            tbl.push_back(v(1, 1, 8'hC1, 0,  0, 8'h00, 2,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC2, 0,  0, 8'h00, 3,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC3, 0,  0, 8'h00, 4,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC4, 0,  0, 8'h00, 5,  0, 0, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC5, 0,  0, 8'h00, 6,  0, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC6, 0,  0, 8'h00, 7,  0, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hC7, 0,  0, 8'h00, 8,  1, 0, 1, 0, 0, 0));
            tbl.push_back(v(1, 1, 8'hEE, 1,  1, 8'hC0, 7,  0, 0, 1, 0, 1, 0));
            tbl.push_back(v(0, 0, 8'h00, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));
            // simultaneous write+read at empty: write wins, read dropped
            tbl.push_back(v(1, 1, 8'hD0, 1,  0, 8'h00, 1,  0, 0, 0, 1, 0, 1));
            tbl.push_back(v(1, 0, 8'h00, 1,  1, 8'hD0, 0,  0, 1, 0, 1, 0, 1));
            tbl.push_back(v(0, 0, 8'h00, 0,  0, 8'h00, 0,  0, 1, 0, 1, 0, 0));

            foreach (tbl[i]) apply(tbl[i], i);
        end

        // stream 40 words with occupancy held at 5: pointers wrap five times
        mdl_q.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0, $sformatf("fill%0d", i));
        for (int i = 5; i < 40; i++) cyc(1'b1, 8'(i), 1'b1, $sformatf("strm%0d", i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, $sformatf("drain%0d", i));
        chk("stream err flags", 32'({overflow, underflow}), 32'd0);
        chk("stream empty", 32'(fifo_empty), 32'd1);

        // reset at count 5 discards everything in one cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, $sformatf("pre_rst%0d", i));
        drive_edge(1'b0, 1'b0, 8'h00, 1'b0);
        mdl_q.delete();
        chk("mid reset fill_count", 32'(fill_count), 32'd0);
        chk("mid reset empty", 32'(fifo_empty), 32'd1);
        drive_edge(1'b1, 1'b0, 8'h00, 1'b1);
        chk("post reset rd_valid", 32'(rd_valid), 32'd0);
`else
        // first-word-fall-through: head word appears without rd_en
        drive_edge(1'b0, 1'b0, 8'h00, 1'b0);
        drive_edge(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft reset empty", 32'(fifo_empty), 32'd1);
        chk("fwft reset rd_valid", 32'(rd_valid), 32'd0);
        drive_edge(1'b1, 1'b1, 8'hA5, 1'b0);
        chk("fwft head data", 32'(rd_data), 32'hA5);
        chk("fwft head valid", 32'(rd_valid), 32'd1);
        chk("fwft not empty", 32'(fifo_empty), 32'd0);
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0);
        chk("fwft hold data", 32'(rd_data), 32'hA5);
        chk("fwft hold valid", 32'(rd_valid), 32'd1);
        drive_edge(1'b1, 1'b0, 8'h00, 1'b1);
        chk("fwft pop empty", 32'(fifo_empty), 32'd1);
        chk("fwft pop valid", 32'(rd_valid), 32'd0);
        drive_edge(1'b1, 1'b1, 8'hB1, 1'b0);
        drive_edge(1'b1, 1'b1, 8'hB2, 1'b0);
        chk("fwft second head", 32'(rd_data), 32'hB1);
        drive_edge(1'b1, 1'b0, 8'h00, 1'b1);
        chk("fwft next head", 32'(rd_data), 32'hB2);
        chk("fwft count", 32'(fill_count), 32'd1);
        chk("fwft err flags", 32'({overflow, underflow}), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
